// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: bus-mapped OUT/OEN/IE/status registers, input synchronizers,
// edge detection and a level interrupt, all in the single core clock domain.
module gpio_pad_ctrl #(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  output logic [31:0]       o_wb_dat,
  output logic              o_wb_ack,
  input  logic [GPIO_W-1:0] i_gpio,
  output logic [GPIO_W-1:0] o_gpio,
  output logic [GPIO_W-1:0] en_gpio,
  output logic              o_irq
);

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_OEN     = 3'd2;
  localparam logic [2:0] REG_RISE_IE = 3'd3;
  localparam logic [2:0] REG_FALL_IE = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  // Handshake: a request is cyc & stb while no ack is outstanding; it is
  // answered by a one-cycle ack on the next edge, which is also the edge where
  // writes land and read data is captured. A held strobe thus acks every other cycle.
  logic       req, wr, rd;
  logic [2:0] reg_sel;
  logic       unused_adr;

  assign req        = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr         = req & i_wb_we;
  assign rd         = req & ~i_wb_we;
  assign reg_sel    = i_wb_adr[4:2];
  assign unused_adr = ^i_wb_adr[1:0];

  logic [31:0]       byte_mask;
  logic [GPIO_W-1:0] bm, wd;

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{i_wb_sel[b]}};
  end

  assign bm = byte_mask[GPIO_W-1:0];
  assign wd = i_wb_dat[GPIO_W-1:0] & bm;

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0] sync, prev_q;
  logic [GPIO_W-1:0] out_q, oen_q, rise_ie_q, fall_ie_q, status_q;
  logic [GPIO_W-1:0] rise, fall, w1c_mask, status_next;
  logic [31:0]       rd_mux;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

  // Clear happens first, so an edge landing on the same cycle as its W1C survives.
  assign w1c_mask    = (wr && reg_sel == REG_STATUS) ? wd : '0;
  assign status_next = (status_q & ~w1c_mask) | (rise & rise_ie_q) | (fall & fall_ie_q);

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_IN:      rd_mux[GPIO_W-1:0] = sync;
      REG_OUT:     rd_mux[GPIO_W-1:0] = out_q;
      REG_OEN:     rd_mux[GPIO_W-1:0] = oen_q;
      REG_RISE_IE: rd_mux[GPIO_W-1:0] = rise_ie_q;
      REG_FALL_IE: rd_mux[GPIO_W-1:0] = fall_ie_q;
      REG_STATUS:  rd_mux[GPIO_W-1:0] = status_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_gpio};
      prev_q <= sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      oen_q     <= '1;
      rise_ie_q <= '0;
      fall_ie_q <= '0;
      status_q  <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_dat  <= '0;
    end else begin
      status_q <= status_next;
      o_wb_ack <= req;
      o_wb_dat <= rd ? rd_mux : '0;
      if (wr) begin
        case (reg_sel)
          REG_OUT:     out_q     <= (out_q & ~bm) | wd;
          REG_OEN:     oen_q     <= (oen_q & ~bm) | wd;
          REG_RISE_IE: rise_ie_q <= (rise_ie_q & ~bm) | wd;
          REG_FALL_IE: fall_ie_q <= (fall_ie_q & ~bm) | wd;
          default:     ;
        endcase
      end
    end
  end

  assign o_gpio  = out_q;
  assign en_gpio = oen_q;
  assign o_irq   = |status_q;

endmodule
